// File: rtl/player_rocket_ctrl.sv
// Player rocket controller: turns fire presses into launches from the ship's
// nose, flies up to two rockets upward per frame and provides sprite draw info.
module player_rocket_ctrl #(
  parameter int SPEED    = 6,
  parameter int COOLDOWN = 8,
  parameter int SHIP_W   = 17,
  parameter int ROCK_H   = 8
) (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic        frame_tick_i,
  input  logic        fire_i,
  input  logic [9:0]  ShipX_i,
  input  logic [9:0]  ShipY_i,
  input  logic [1:0]  hit_i,
  input  logic [9:0]  DrawX_i,
  input  logic [9:0]  DrawY_i,
  output logic [1:0]  rock_active_o,
  output logic [9:0]  Rock0X_o,
  output logic [9:0]  Rock0Y_o,
  output logic [9:0]  Rock1X_o,
  output logic [9:0]  Rock1Y_o,
  output logic [1:0]  rock_on_o,
  output logic [1:0]  SRockX_o,
  output logic [2:0]  SRockY_o,
  output logic        launch_o,
  output logic [15:0] shots_fired_o
);

  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  localparam logic [9:0]    LAUNCH_DX = 10'((SHIP_W - 3) / 2);
  localparam logic [9:0]    SPEED_V   = 10'(SPEED);
  localparam logic [9:0]    ROCK_H_V  = 10'(ROCK_H);
  localparam logic [CW-1:0] COOL_V    = CW'(COOLDOWN);

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } slot_state_e;

  slot_state_e   state_q [2];
  slot_state_e   state_d [2];
  logic [9:0]    rockX_q [2];
  logic [9:0]    rockX_d [2];
  logic [9:0]    rockY_q [2];
  logic [9:0]    rockY_d [2];

  logic          fire_prev_q,    fire_prev_d;
  logic          fire_pending_q, fire_pending_d;
  logic [CW-1:0] cooldown_q,     cooldown_d;
  logic          launch_q,       launch_d;
  logic [15:0]   shots_q,        shots_d;

  logic          fireRise;
  logic          pendingNow;
  logic          anyIdle;
  logic          spawnOk;
  logic          spawnSlot;
  logic [9:0]    launchX;
  logic [9:0]    launchY;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        rockX_q[i] <= '0;
        rockY_q[i] <= '0;
      end
      fire_prev_q    <= 1'b0;
      fire_pending_q <= 1'b0;
      cooldown_q     <= '0;
      launch_q       <= 1'b0;
      shots_q        <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        rockX_q[i] <= rockX_d[i];
        rockY_q[i] <= rockY_d[i];
      end
      fire_prev_q    <= fire_prev_d;
      fire_pending_q <= fire_pending_d;
      cooldown_q     <= cooldown_d;
      launch_q       <= launch_d;
      shots_q        <= shots_d;
    end
  end

  // A press coinciding with the tick counts on that tick; slot choice uses
  // registered state, so a slot freed by a hit this cycle waits a frame.
  always_comb begin
    fireRise   = fire_i & ~fire_prev_q;
    pendingNow = fire_pending_q | fireRise;
    anyIdle    = (state_q[0] == IDLE) | (state_q[1] == IDLE);
    spawnOk    = frame_tick_i & pendingNow & (cooldown_q == '0) & anyIdle;
    spawnSlot  = (state_q[0] == IDLE) ? 1'b0 : 1'b1;
    launchX    = ShipX_i + LAUNCH_DX;
    launchY    = (ShipY_i < ROCK_H_V) ? 10'd0 : (ShipY_i - ROCK_H_V);
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      rockX_d[i] = rockX_q[i];
      rockY_d[i] = rockY_q[i];
    end
    fire_prev_d    = fire_i;
    fire_pending_d = frame_tick_i ? 1'b0 : pendingNow;
    cooldown_d     = cooldown_q;
    launch_d       = spawnOk;
    shots_d        = shots_q + {15'd0, spawnOk};

    for (int i = 0; i < 2; i++) begin
      case (state_q[i])
        FLYING: begin
          if (hit_i[i]) begin
            state_d[i] = IDLE;
          end else if (frame_tick_i) begin
            if (rockY_q[i] < SPEED_V) begin
              state_d[i] = IDLE;
            end else begin
              rockY_d[i] = rockY_q[i] - SPEED_V;
            end
          end
        end
        default: begin
          if (spawnOk && (spawnSlot == 1'(i))) begin
            state_d[i] = FLYING;
            rockX_d[i] = launchX;
            rockY_d[i] = launchY;
          end
        end
      endcase
    end

    if (spawnOk) begin
      cooldown_d = COOL_V;
    end else if (frame_tick_i && (cooldown_q != '0)) begin
      cooldown_d = cooldown_q - CW'(1);
    end
  end

  logic [9:0] drawDx [2];
  logic [9:0] drawDy [2];
  logic [1:0] onVec;

  // Offsets are only trusted after the >= checks, so the subtraction never wraps.
  always_comb begin
    onVec    = 2'b00;
    SRockX_o = 2'd0;
    SRockY_o = 3'd0;
    for (int i = 0; i < 2; i++) begin
      drawDx[i] = DrawX_i - rockX_q[i];
      drawDy[i] = DrawY_i - rockY_q[i];
      onVec[i]  = ~Reset_i & (state_q[i] == FLYING)
                & (DrawX_i >= rockX_q[i]) & (drawDx[i] <= 10'd2)
                & (DrawY_i >= rockY_q[i]) & (drawDy[i] <= 10'd7);
    end
    if (onVec[0]) begin
      SRockX_o = drawDx[0][1:0];
      SRockY_o = drawDy[0][2:0];
    end else if (onVec[1]) begin
      SRockX_o = drawDx[1][1:0];
      SRockY_o = drawDy[1][2:0];
    end
  end

  assign rock_on_o     = onVec;
  assign rock_active_o = {state_q[1] == FLYING, state_q[0] == FLYING};
  assign Rock0X_o      = rockX_q[0];
  assign Rock0Y_o      = rockY_q[0];
  assign Rock1X_o      = rockX_q[1];
  assign Rock1Y_o      = rockY_q[1];
  assign launch_o      = launch_q;
  assign shots_fired_o = shots_q;

endmodule

// File: tb/tb_player_rocket_ctrl.sv
// Directed bench for player_rocket_ctrl: a per-cycle vector table for the
// launch/cooldown/hit flow plus hand sequences for reset, exit and drawing.
module tb_player_rocket_ctrl;

  logic        clk;
  logic        reset;
  logic        frameTick;
  logic        fire;
  logic [9:0]  shipX;
  logic [9:0]  shipY;
  logic [1:0]  hit;
  logic [9:0]  drawX;
  logic [9:0]  drawY;
  logic [1:0]  rockActive;
  logic [9:0]  rock0X, rock0Y, rock1X, rock1Y;
  logic [1:0]  rockOn;
  logic [1:0]  sRockX;
  logic [2:0]  sRockY;
  logic        launch;
  logic [15:0] shotsFired;

  int checkCount = 0;
  int passCount  = 0;

  player_rocket_ctrl dut (
    .Clk_i         (clk),
    .Reset_i       (reset),
    .frame_tick_i  (frameTick),
    .fire_i        (fire),
    .ShipX_i       (shipX),
    .ShipY_i       (shipY),
    .hit_i         (hit),
    .DrawX_i       (drawX),
    .DrawY_i       (drawY),
    .rock_active_o (rockActive),
    .Rock0X_o      (rock0X),
    .Rock0Y_o      (rock0Y),
    .Rock1X_o      (rock1X),
    .Rock1Y_o      (rock1Y),
    .rock_on_o     (rockOn),
    .SRockX_o      (sRockX),
    .SRockY_o      (sRockY),
    .launch_o      (launch),
    .shots_fired_o (shotsFired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tick;
    logic        fire;
    logic [1:0]  hit;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic [1:0]  expActive;
    logic        expLaunch;
    logic [9:0]  expR0X;
    logic [9:0]  expR0Y;
    logic [9:0]  expR1X;
    logic [9:0]  expR1Y;
    logic [15:0] expShots;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input logic t, input logic f, input logic [1:0] h,
                                 input logic [9:0] sx, input logic [9:0] sy,
                                 input logic [1:0] act, input logic lau,
                                 input logic [9:0] r0x, input logic [9:0] r0y,
                                 input logic [9:0] r1x, input logic [9:0] r1y,
                                 input logic [15:0] shots);
    vec_t v;
    v.tick = t; v.fire = f; v.hit = h; v.sx = sx; v.sy = sy;
    v.expActive = act; v.expLaunch = lau;
    v.expR0X = r0x; v.expR0Y = r0y; v.expR1X = r1x; v.expR1Y = r1y;
    v.expShots = shots;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One clock: drive inputs, clock edge, then settle 1ns so outputs are sampled off the edge.
  task automatic applyStimulus(input logic t, input logic f, input logic [1:0] h);
    frameTick = t;
    fire      = f;
    hit       = h;
    @(posedge clk);
    #1;
    frameTick = 1'b0;
    hit       = 2'b00;
  endtask

  task automatic checkRegs(input string tag, input logic [1:0] act, input logic lau,
                           input logic [9:0] r0x, input logic [9:0] r0y,
                           input logic [9:0] r1x, input logic [9:0] r1y,
                           input logic [15:0] shots);
    checkOutput({tag, ".active"}, 32'(rockActive), 32'(act));
    checkOutput({tag, ".launch"}, 32'(launch),     32'(lau));
    checkOutput({tag, ".r0x"},    32'(rock0X),     32'(r0x));
    checkOutput({tag, ".r0y"},    32'(rock0Y),     32'(r0y));
    checkOutput({tag, ".r1x"},    32'(rock1X),     32'(r1x));
    checkOutput({tag, ".r1y"},    32'(rock1Y),     32'(r1y));
    checkOutput({tag, ".shots"},  32'(shotsFired), 32'(shots));
  endtask

  task automatic checkDraw(input string tag, input logic [9:0] dx, input logic [9:0] dy,
                           input logic [1:0] on, input logic [1:0] sx, input logic [2:0] sy);
    drawX = dx;
    drawY = dy;
    #1;
    checkOutput({tag, ".rock_on"}, 32'(rockOn), 32'(on));
    checkOutput({tag, ".SRockX"},  32'(sRockX), 32'(sx));
    checkOutput({tag, ".SRockY"},  32'(sRockY), 32'(sy));
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b00);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frameTick = 1'b0; fire = 1'b1; hit = 2'b00;
    shipX = 10'd300; shipY = 10'd440; drawX = 10'd0; drawY = 10'd0;

    // Reset held with fire high.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 2'b00);
    checkRegs("reset", 2'b00, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 16'd0);
    checkDraw("resetDraw", 10'd0, 10'd0, 2'b00, 2'd0, 3'd0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b00);
      checkRegs($sformatf("postReset%0d", i), 2'b00, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 16'd0);
    end

    //                  tick fire hit    sx      sy      act  lau r0x     r0y     r1x     r1y     shots
    vecs.push_back(mkVec(0, 0, 2'b00, 10'd300, 10'd440, 2'b00, 0, 10'd0,   10'd0,   10'd0,   10'd0,   16'd0));
    vecs.push_back(mkVec(0, 1, 2'b00, 10'd300, 10'd440, 2'b00, 0, 10'd0,   10'd0,   10'd0,   10'd0,   16'd0));
    vecs.push_back(mkVec(1, 1, 2'b00, 10'd300, 10'd440, 2'b01, 1, 10'd307, 10'd432, 10'd0,   10'd0,   16'd1));
    vecs.push_back(mkVec(0, 0, 2'b00, 10'd300, 10'd440, 2'b01, 0, 10'd307, 10'd432, 10'd0,   10'd0,   16'd1));
    vecs.push_back(mkVec(1, 0, 2'b00, 10'd300, 10'd440, 2'b01, 0, 10'd307, 10'd426, 10'd0,   10'd0,   16'd1));
    vecs.push_back(mkVec(1, 0, 2'b00, 10'd300, 10'd440, 2'b01, 0, 10'd307, 10'd420, 10'd0,   10'd0,   16'd1));
    vecs.push_back(mkVec(0, 1, 2'b00, 10'd300, 10'd440, 2'b01, 0, 10'd307, 10'd420, 10'd0,   10'd0,   16'd1));
    vecs.push_back(mkVec(1, 1, 2'b00, 10'd300, 10'd440, 2'b01, 0, 10'd307, 10'd414, 10'd0,   10'd0,   16'd1));
    vecs.push_back(mkVec(0, 0, 2'b00, 10'd300, 10'd440, 2'b01, 0, 10'd307, 10'd414, 10'd0,   10'd0,   16'd1));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mkVec(1, 0, 2'b00, 10'd300, 10'd440, 2'b01, 0, 10'd307, 10'(414 - 6*k), 10'd0, 10'd0, 16'd1));
    vecs.push_back(mkVec(0, 1, 2'b00, 10'd300, 10'd440, 2'b01, 0, 10'd307, 10'd384, 10'd0,   10'd0,   16'd1));
    vecs.push_back(mkVec(1, 1, 2'b00, 10'd300, 10'd440, 2'b11, 1, 10'd307, 10'd378, 10'd307, 10'd432, 16'd2));
    vecs.push_back(mkVec(0, 0, 2'b00, 10'd300, 10'd440, 2'b11, 0, 10'd307, 10'd378, 10'd307, 10'd432, 16'd2));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mkVec(1, 0, 2'b00, 10'd300, 10'd440, 2'b11, 0, 10'd307, 10'(378 - 6*k), 10'd307, 10'(432 - 6*k), 16'd2));
    vecs.push_back(mkVec(0, 1, 2'b00, 10'd300, 10'd440, 2'b11, 0, 10'd307, 10'd330, 10'd307, 10'd384, 16'd2));
    vecs.push_back(mkVec(1, 1, 2'b00, 10'd300, 10'd440, 2'b11, 0, 10'd307, 10'd324, 10'd307, 10'd378, 16'd2));
    vecs.push_back(mkVec(0, 0, 2'b00, 10'd300, 10'd440, 2'b11, 0, 10'd307, 10'd324, 10'd307, 10'd378, 16'd2));
    vecs.push_back(mkVec(0, 1, 2'b00, 10'd300, 10'd440, 2'b11, 0, 10'd307, 10'd324, 10'd307, 10'd378, 16'd2));
    vecs.push_back(mkVec(1, 1, 2'b01, 10'd300, 10'd440, 2'b10, 0, 10'd307, 10'd324, 10'd307, 10'd372, 16'd2));
    vecs.push_back(mkVec(0, 0, 2'b00, 10'd300, 10'd440, 2'b10, 0, 10'd307, 10'd324, 10'd307, 10'd372, 16'd2));
    vecs.push_back(mkVec(0, 1, 2'b00, 10'd100, 10'd440, 2'b10, 0, 10'd307, 10'd324, 10'd307, 10'd372, 16'd2));
    vecs.push_back(mkVec(1, 1, 2'b00, 10'd100, 10'd440, 2'b11, 1, 10'd107, 10'd432, 10'd307, 10'd366, 16'd3));
    vecs.push_back(mkVec(0, 0, 2'b10, 10'd100, 10'd440, 2'b01, 0, 10'd107, 10'd432, 10'd307, 10'd366, 16'd3));
    vecs.push_back(mkVec(1, 0, 2'b10, 10'd100, 10'd440, 2'b01, 0, 10'd107, 10'd426, 10'd307, 10'd366, 16'd3));

    foreach (vecs[i]) begin
      shipX = vecs[i].sx;
      shipY = vecs[i].sy;
      applyStimulus(vecs[i].tick, vecs[i].fire, vecs[i].hit);
      checkRegs($sformatf("row%0d", i), vecs[i].expActive, vecs[i].expLaunch,
                vecs[i].expR0X, vecs[i].expR0Y, vecs[i].expR1X, vecs[i].expR1Y,
                vecs[i].expShots);
    end

    // Reset mid-flight, even with a tick present, clears everything.
    pulseReset();
    checkRegs("midReset", 2'b00, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 16'd0);

    // Rocket at Y=5 leaves the screen without wrapping.
    shipX = 10'd0; shipY = 10'd13;
    applyStimulus(1'b0, 1'b1, 2'b00);
    applyStimulus(1'b1, 1'b1, 2'b00);
    checkRegs("exit5.spawn", 2'b01, 1'b1, 10'd7, 10'd5, 10'd0, 10'd0, 16'd1);
    applyStimulus(1'b1, 1'b0, 2'b00);
    checkRegs("exit5.gone", 2'b00, 1'b0, 10'd7, 10'd5, 10'd0, 10'd0, 16'd1);

    // Rocket at Y=6 lands on row 0 and survives one more tick; hit on an idle slot is ignored.
    pulseReset();
    shipY = 10'd14;
    applyStimulus(1'b0, 1'b1, 2'b00);
    applyStimulus(1'b1, 1'b1, 2'b00);
    checkRegs("exit6.spawn", 2'b01, 1'b1, 10'd7, 10'd6, 10'd0, 10'd0, 16'd1);
    applyStimulus(1'b1, 1'b0, 2'b10);
    checkRegs("exit6.top", 2'b01, 1'b0, 10'd7, 10'd0, 10'd0, 10'd0, 16'd1);
    applyStimulus(1'b1, 1'b0, 2'b00);
    checkRegs("exit6.gone", 2'b00, 1'b0, 10'd7, 10'd0, 10'd0, 10'd0, 16'd1);

    // Ship too close to the top: launch Y clamps to 0.
    pulseReset();
    shipY = 10'd3;
    applyStimulus(1'b0, 1'b1, 2'b00);
    applyStimulus(1'b1, 1'b1, 2'b00);
    checkRegs("clampY", 2'b01, 1'b1, 10'd7, 10'd0, 10'd0, 10'd0, 16'd1);

    // Draw path around rocket 0 at (307,432).
    pulseReset();
    shipX = 10'd300; shipY = 10'd440;
    applyStimulus(1'b0, 1'b1, 2'b00);
    applyStimulus(1'b1, 1'b1, 2'b00);
    checkRegs("drawSpawn", 2'b01, 1'b1, 10'd307, 10'd432, 10'd0, 10'd0, 16'd1);
    checkDraw("drawIn",     10'd309, 10'd439, 2'b01, 2'd2, 3'd7);
    checkDraw("drawRight",  10'd310, 10'd439, 2'b00, 2'd0, 3'd0);
    checkDraw("drawCorner", 10'd307, 10'd432, 2'b01, 2'd0, 3'd0);
    checkDraw("drawBelow",  10'd308, 10'd440, 2'b00, 2'd0, 3'd0);
    checkDraw("drawLeft",   10'd306, 10'd435, 2'b00, 2'd0, 3'd0);

    // Second rocket after cooldown expires, drawn through the rocket-1 path.
    shipX = 10'd200;
    applyStimulus(1'b0, 1'b0, 2'b00);
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b1, 2'b00);
    applyStimulus(1'b1, 1'b1, 2'b00);
    checkRegs("draw1Spawn", 2'b11, 1'b1, 10'd307, 10'd378, 10'd207, 10'd432, 16'd2);
    checkDraw("draw1In", 10'd208, 10'd435, 2'b10, 2'd1, 3'd3);
    checkDraw("draw0In", 10'd307, 10'd378, 2'b01, 2'd0, 3'd0);

    // Draw outputs forced low while reset is held.
    reset = 1'b1;
    checkDraw("drawReset", 10'd208, 10'd435, 2'b00, 2'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkRegs("finalReset", 2'b00, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 16'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
